// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if -- byte write handshake between a core and uart_tx_ctrl.
//   wr_opt_byte : [8] = valid, [7:0] = byte (driven by the core)
//   wr_ready    : transmitter can take a byte this cycle (driven by uart_tx_ctrl)
interface uart_tx_ctrl_if;
  logic [8:0] wr_opt_byte;
  logic       wr_ready;

  modport master (output wr_opt_byte, input  wr_ready);
  modport slave  (input  wr_opt_byte, output wr_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- 8N1 UART transmitter with a small transmit queue.
//   CLK      : clock, all state updates on the rising edge
//   RST      : synchronous active-high reset
//   wr       : uart_tx_ctrl_if.slave (wr_opt_byte in, wr_ready out)
//   tx_line  : serial line, idle high, registered
//   busy     : a byte is queued or a frame is in flight
//   tx_done  : one-cycle pulse in the last cycle of each stop bit
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue;
// otherwise the queue is a single holding register and FIFO_DEPTH is ignored.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  wr,
  output logic           tx_line,
  output logic           busy,
  output logic           tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Elaboration-time guard on parameter ranges.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 ||
      FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_ctrl: illegal CLKS_PER_BIT or FIFO_DEPTH");
  end

  logic       q_push;
  logic       q_pop;
  logic       q_full;
  logic       q_empty;
  logic [7:0] q_head;

  // Ready depends only on registered occupancy, never on the request.
  assign wr.wr_ready = ~q_full;
  assign q_push      = wr.wr_opt_byte[8] & ~q_full;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  assign q_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign q_empty = (occ == '0);
  assign q_head  = mem[rd_ptr];

  // Queue storage; contents need no reset, the pointers define validity.
  always_ff @(posedge CLK) begin
    if (!RST && q_push) mem[wr_ptr] <= wr.wr_opt_byte[7:0];
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (q_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({q_push, q_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end
`else
  logic       hold_vld;
  logic [7:0] hold_data;

  assign q_full  = hold_vld;
  assign q_empty = ~hold_vld;
  assign q_head  = hold_data;

  // Single holding register; push needs it empty and pop needs it full,
  // so both never happen on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (q_push) begin
      hold_vld  <= 1'b1;
      hold_data <= wr.wr_opt_byte[7:0];
    end else if (q_pop) begin
      hold_vld  <= 1'b0;
    end
  end
`endif

  logic [1:0]       state,    state_nxt;
  logic [CNT_W-1:0] baud_cnt, cnt_nxt;
  logic [2:0]       bit_idx,  bit_nxt;
  logic [7:0]       shift_q,  shift_nxt;
  logic             tx_nxt;
  logic             done_nxt;

  // State register; tx_line and tx_done are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_line  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_idx  <= bit_nxt;
      shift_q  <= shift_nxt;
      tx_line  <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next-state logic; the baud counter reloads on every state/bit change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift_q;
    q_pop     = 1'b0;
    tx_nxt    = 1'b1;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          shift_nxt = q_head;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt == '0) begin
          cnt_nxt   = CNT_LOAD;
          bit_nxt   = '0;
          state_nxt = ST_DATA;
        end else begin
          cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt == '0) begin
          cnt_nxt = CNT_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt == '0) begin
          // Chain straight into the next frame when one is waiting.
          if (!q_empty) begin
            q_pop     = 1'b1;
            shift_nxt = q_head;
            cnt_nxt   = CNT_LOAD;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
    done_nxt = (state_nxt == ST_STOP) && (cnt_nxt == '0);
  end

  assign busy = (state != ST_IDLE) | ~q_empty;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the transmit queue depth (power of two, 2..16); used only when UART_TX_FIFO_EN is defined.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_opt_byte  input  9  core write request: bit 8 = valid, bits 7:0 = byte.
REQ-006 SHALL have port wr_ready  output  1  high when a valid byte presented this cycle will be accepted.
REQ-007 SHALL have port tx_line  output  1  serial 8N1 line, idle high, registered.
REQ-008 SHALL have port busy  output  1  high while any byte is queued or a frame is in flight.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 SHALL accept a byte on the rising edge where wr_opt_byte[8]=1 and wr_ready=1; bits 7:0 are ignored whenever bit 8 is 0.
REQ-011 SHALL derive wr_ready only from registered queue occupancy (ready = not full), never from wr_opt_byte, so there is no combinational path input->wr_ready.
REQ-012 SHALL keep wr_ready low for the whole cycle in which the queue is full, even if a pop occurs on the same edge.
REQ-013 SHALL, on simultaneous push and pop with the queue neither empty nor full, leave occupancy unchanged and preserve FIFO order.
REQ-014 SHALL implement serializer states IDLE, START, DATA, STOP with a down-counting baud counter of width clog2(CLKS_PER_BIT).
REQ-015 SHALL, in IDLE with a non-empty queue, pop the head byte into the shift register and enter START on the same edge.
REQ-016 SHALL hold tx_line low for CLKS_PER_BIT cycles in START, then in DATA send 8 bits LSB first for CLKS_PER_BIT cycles each, then in STOP hold tx_line high for CLKS_PER_BIT cycles.
REQ-017 SHALL, at STOP end with a non-empty queue, pop and go directly to START with no idle cycle, giving a frame pitch of exactly 10*CLKS_PER_BIT cycles; otherwise go to IDLE.
REQ-018 SHALL, for a byte accepted on edge E into an idle, empty block, drive tx_line low in the cycle after edge E+1 (2-cycle latency).
REQ-019 SHALL assert busy = (state != IDLE) or (queue not empty), combinationally from registers.
REQ-020 SHALL assert tx_done exactly once per frame, in the final cycle of STOP.

Reset
REQ-021 SHALL, on any edge with RST=1, set state=IDLE, empty the queue, clear the counters and the shift register, and drive tx_line=1, wr_ready=1, busy=0, tx_done=0 from the next cycle.
REQ-022 SHALL, when reset occurs mid-frame, abort the frame immediately with no completing stop bit and no tx_done pulse; the byte accepted on the reset edge is discarded.

Configuration
REQ-023 SHALL, with UART_TX_FIFO_EN defined, implement the queue as a FIFO_DEPTH-entry circular buffer with wrapping read and write pointers and an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-024 SHALL, without UART_TX_FIFO_EN, implement the queue as a single holding register (depth 1, wr_ready = holding register empty), ignore FIFO_DEPTH, and keep all other timing identical.

Verification (CLKS_PER_BIT=4, UART_TX_FIFO_EN defined, FIFO_DEPTH=4)
REQ-025 SHALL cover: push 0x55 when idle -> tx_line low 2 cycles after accept, bit sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each, one tx_done, busy low after 40 frame cycles.
REQ-026 SHALL cover: valid held high with bytes 0x01..0x06 -> the first pops immediately, four more fill the queue, wr_ready drops, 0x06 is accepted only after the next pop, and six frames go out back-to-back at a 40-cycle pitch in order.
REQ-027 SHALL cover: wr_opt_byte=0x0AA (valid=0) for 20 cycles -> no accept, tx_line stays high, busy=0.
REQ-028 SHALL cover: RST pulsed during DATA bit 3 with 2 bytes queued -> next cycle tx_line=1, busy=0, wr_ready=1, no tx_done, and no further frames.
REQ-029 SHALL cover: without UART_TX_FIFO_EN, push 0x80 then 0x81 back-to-back -> 0x81 accepted on the edge after 0x80 pops, then wr_ready stays low until the 0x80 STOP end; frames 0x80, 0x81 at a 40-cycle pitch.
